// File: rtl/i2c_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_mem_if
// Brief    : Open-drain I2C bus bundle (SCL, SDA in, SDA pull-down enable).
// Revision : 1.0
// ============================================================================
interface i2c_slave_mem_if;
    logic scl;
    logic sda_i;
    logic sda_oe;

    modport master (output scl, output sda_i, input sda_oe);
    modport slave  (input scl, input sda_i, output sda_oe);
endinterface
`default_nettype wire

// File: rtl/i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_mem
// Brief    : I2C target with a pointer-addressed byte register file.
// Revision : 1.0
// ============================================================================
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR  = 7'h12,
    parameter int         MEM_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    i2c_slave_mem_if.slave               bus,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_pulse,
    output logic [7:0]                   last_byte,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
    output logic [7:0]                   mem_rd_data
);
    localparam int c_ptr_w = $clog2(MEM_DEPTH);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_addr      = 4'd1;
    localparam logic [3:0] c_st_addr_ack  = 4'd2;
    localparam logic [3:0] c_st_ptr       = 4'd3;
    localparam logic [3:0] c_st_ptr_ack   = 4'd4;
    localparam logic [3:0] c_st_wdata     = 4'd5;
    localparam logic [3:0] c_st_wdata_ack = 4'd6;
    localparam logic [3:0] c_st_rdata     = 4'd7;
    localparam logic [3:0] c_st_rack_chk  = 4'd8;
    localparam logic [3:0] c_st_wait_stop = 4'd9;

    logic               r_scl_s1, r_scl_s2, r_scl_d;
    logic               r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]         r_state;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [c_ptr_w-1:0] r_ptr;
    logic [7:0]         r_mem [MEM_DEPTH];
    logic               r_rw;
    logic               r_ack;
    logic               r_sda_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_pulse;
    logic [7:0]         r_last_byte;

    logic               w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]         w_byte;
    logic [7:0]         w_rd_byte;

    // Start/stop need SCL stably high, so an SDA edge coincident with an SCL edge is data.
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_rd_byte  = r_mem[r_ptr];

    assign bus.sda_oe  = r_sda_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign wr_pulse    = r_wr_pulse;
    assign last_byte   = r_last_byte;
    assign mem_rd_data = r_mem[mem_rd_addr];

    // Synchronizers reset low so a released bus never looks like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b0;
            r_scl_s2 <= 1'b0;
            r_scl_d  <= 1'b0;
            r_sda_s1 <= 1'b0;
            r_sda_s2 <= 1'b0;
            r_sda_d  <= 1'b0;
        end else begin
            r_scl_s1 <= bus.scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= bus.sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_ack       <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_pulse  <= 1'b0;
            r_last_byte <= 8'd0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'd0;
        end else begin
            r_done     <= 1'b0;
            r_wr_pulse <= 1'b0;
            if (w_stop) begin
                r_state  <= c_st_idle;
                r_sda_oe <= 1'b0;
                r_ack    <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= r_busy;
            end else if (w_start) begin
                r_state  <= c_st_addr;
                r_bitcnt <= 3'd0;
                r_sda_oe <= 1'b0;
                r_ack    <= 1'b0;
            end else begin
                case (r_state)
                    c_st_addr, c_st_ptr, c_st_wdata: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_last_byte <= w_byte;
                                if (r_state == c_st_addr) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= (w_byte[7:1] == DEV_ADDR) ? c_st_addr_ack : c_st_wait_stop;
                                end else if (r_state == c_st_ptr) begin
                                    r_ptr   <= w_byte[c_ptr_w-1:0];
                                    r_state <= c_st_ptr_ack;
                                end else begin
                                    r_mem[r_ptr] <= w_byte;
                                    r_wr_pulse   <= 1'b1;
                                    r_ptr        <= r_ptr + c_ptr_w'(1);
                                    r_state      <= c_st_wdata_ack;
                                end
                            end
                        end
                    end
                    // First SCL fall drives the ACK low, the second ends it.
                    c_st_addr_ack, c_st_ptr_ack, c_st_wdata_ack: begin
                        if (w_scl_fall) begin
                            if (!r_ack) begin
                                r_sda_oe <= 1'b1;
                                r_ack    <= 1'b1;
                                if (r_state == c_st_addr_ack) r_busy <= 1'b1;
                            end else begin
                                r_ack <= 1'b0;
                                if (r_state == c_st_addr_ack && r_rw) begin
                                    r_shift  <= {w_rd_byte[6:0], 1'b0};
                                    r_sda_oe <= ~w_rd_byte[7];
                                    r_ptr    <= r_ptr + c_ptr_w'(1);
                                    r_state  <= c_st_rdata;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == c_st_addr_ack) ? c_st_ptr : c_st_wdata;
                                end
                            end
                        end
                    end
                    c_st_rdata: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_ack    <= 1'b0;
                                r_state  <= c_st_rack_chk;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    c_st_rack_chk: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) r_state <= c_st_wait_stop;
                            else          r_ack   <= 1'b1;
                        end else if (w_scl_fall && r_ack) begin
                            r_ack    <= 1'b0;
                            r_shift  <= {w_rd_byte[6:0], 1'b0};
                            r_sda_oe <= ~w_rd_byte[7];
                            r_ptr    <= r_ptr + c_ptr_w'(1);
                            r_state  <= c_st_rdata;
                        end
                    end
                    c_st_idle, c_st_wait_stop: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= c_st_idle;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_mem
// Brief    : Bus-level master driving i2c_slave_mem against a memory model.
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_mem;
    localparam int         c_q   = 8;
    localparam logic [6:0] c_dev = 7'h12;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, done, wr_pulse;
    logic [7:0] last_byte, mem_rd_data;
    logic [3:0] mem_rd_addr;
    logic       sda_drv;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_done  = 0;
    int n_oe    = 0;

    logic [7:0] m_mem [16];
    int         m_ptr;

    i2c_slave_mem_if u_if ();
    assign u_if.sda_i = sda_drv & ~u_if.sda_oe;

    i2c_slave_mem #(.DEV_ADDR(c_dev), .MEM_DEPTH(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_if),
        .busy        (busy),
        .done        (done),
        .wr_pulse    (wr_pulse),
        .last_byte   (last_byte),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse)    n_wr++;
        if (done)        n_done++;
        if (u_if.sda_oe) n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (c_q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wq();
        u_if.scl = 1'b1; wq();
        sda_drv = 1'b0; wq();
        u_if.scl = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wq();
        u_if.scl = 1'b1; wq();
        sda_drv = 1'b1; wq(); wq();
    endtask

    task automatic put_bit(input bit b);
        sda_drv = b; wq();
        u_if.scl = 1'b1; wq(); wq();
        u_if.scl = 1'b0; wq();
    endtask

    task automatic get_bit(output bit v);
        sda_drv = 1'b1; wq();
        u_if.scl = 1'b1; wq();
        v = u_if.sda_i; wq();
        u_if.scl = 1'b0; wq();
    endtask

    task automatic put_byte(input logic [7:0] b, output bit ack);
        bit v;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(v);
        ack = ~v;
    endtask

    task automatic get_byte(output logic [7:0] d);
        bit v;
        for (int i = 7; i >= 0; i--) begin
            get_bit(v);
            d[i] = v;
        end
    endtask

    // Write transaction: address, pointer, then n data bytes (byte i = data[8i+:8]).
    task automatic wr_txn(input logic [7:0] addr, input logic [7:0] ptr, input int n,
                          input logic [31:0] data, input bit stop);
        bit         ack, hit;
        int         wr0, dn0, oe0;
        logic [7:0] exp_last;
        wr0 = n_wr; dn0 = n_done; oe0 = n_oe;
        hit = (addr[7:1] == c_dev) && !addr[0];
        bus_start();
        put_byte(addr, ack);
        check("addr_ack", ack, hit);
        exp_last = addr;
        if (hit) begin
            check("busy_on", busy, 1);
            put_byte(ptr, ack);
            check("ptr_ack", ack, 1);
            m_ptr    = ptr % 16;
            exp_last = ptr;
            for (int i = 0; i < n; i++) begin
                put_byte(data[8*i +: 8], ack);
                check("data_ack", ack, 1);
                m_mem[m_ptr] = data[8*i +: 8];
                m_ptr        = (m_ptr + 1) % 16;
                exp_last     = data[8*i +: 8];
            end
        end else begin
            put_byte(data[7:0], ack);
            check("data_nack", ack, 0);
            check("oe_quiet", n_oe - oe0, 0);
            check("busy_off", busy, 0);
        end
        check("wr_pulses", n_wr - wr0, hit ? n : 0);
        check("last_byte", last_byte, exp_last);
        if (stop) begin
            bus_stop();
            check("done_cnt", n_done - dn0, hit);
            check("busy_end", busy, 0);
        end
    endtask

    // Repeated-START read of n bytes from the model pointer, NACK on the last.
    task automatic rd_txn(input int n);
        bit         ack;
        int         dn0;
        logic [7:0] d;
        dn0 = n_done;
        bus_start();
        put_byte({c_dev, 1'b1}, ack);
        check("rd_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            get_byte(d);
            check("rd_data", d, m_mem[m_ptr]);
            m_ptr = (m_ptr + 1) % 16;
            put_bit(i == n - 1);
        end
        check("rd_release", u_if.sda_oe, 0);
        bus_stop();
        check("rd_done", n_done - dn0, 1);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mem_rd_addr = 4'(i);
            #1;
            check("mem", mem_rd_data, m_mem[i]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ack;
        logic [6:0] a;
        rst         = 1'b1;
        u_if.scl    = 1'b1;
        sda_drv     = 1'b1;
        mem_rd_addr = 4'd0;
        m_ptr       = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_oe", u_if.sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr", wr_pulse, 0);
        check("rst_last", last_byte, 0);
        check("rst_mem0", mem_rd_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        wr_txn(8'h24, 8'h03, 1, 32'h000000A5, 1'b1);
        check_mem();
        wr_txn(8'h24, 8'h03, 0, 32'h0, 1'b0);
        rd_txn(1);
        wr_txn(8'h68, 8'h00, 0, 32'h0000005A, 1'b1);
        wr_txn(8'h24, 8'h0F, 2, 32'h00002211, 1'b1);
        wr_txn(8'h24, 8'h00, 3, 32'h00CCBBAA, 1'b1);
        wr_txn(8'h24, 8'h00, 0, 32'h0, 1'b0);
        rd_txn(3);

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: wr_txn(8'h24, 8'($urandom), int'($urandom_range(1, 4)), $urandom, 1'b1);
                1: begin
                    wr_txn(8'h24, 8'($urandom), 0, 32'h0, 1'b0);
                    rd_txn(int'($urandom_range(1, 3)));
                end
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == c_dev) a = a + 7'd1;
                    wr_txn({a, 1'b0}, 8'h00, 0, $urandom, 1'b1);
                end
            endcase
        end
        check_mem();

        // Reset while the target pulls SDA low for a 0 data bit.
        wr_txn(8'h24, 8'h05, 1, 32'h0000003C, 1'b1);
        wr_txn(8'h24, 8'h05, 0, 32'h0, 1'b0);
        bus_start();
        put_byte({c_dev, 1'b1}, ack);
        check("rst_rd_ack", ack, 1);
        check("rd_drive0", u_if.sda_oe, 1);
        rst = 1'b1;
        #1;
        check("rst_release", u_if.sda_oe, 0);
        for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wr_txn(8'h24, 8'h07, 2, 32'h00005E81, 1'b1);
        check_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
